// File: rtl/fsm_stimulus_checker.sv
// rtl/fsm_stimulus_checker.sv - serial stimulus driver and cycle-accurate monitor for the A/B toggle FSM
module fsm_stimulus_checker #(
  parameter int   MAX_LEN    = 16,
  parameter int   LEN_W      = 5,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  output logic               y_out,
  input  logic               x_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [LEN_W-1:0]   err_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE} ctrl_t;

  localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

  ctrl_t              ctrl_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx_q;
  logic [LEN_W-1:0]   err_q;
  logic [LEN_W-1:0]   err_d;
  logic [LEN_W-1:0]   len_clamped;
  logic               exp_state_q;
  logic               y_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic               mismatch;

  always_comb begin
    len_clamped = (length > MAX_LEN_W) ? MAX_LEN_W : length;
    mismatch    = (x_in != exp_state_q);
    err_d       = err_q;
    if (mismatch && (err_q != '1)) err_d = err_q + LEN_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q      <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      err_q       <= '0;
      exp_state_q <= 1'b0;
      y_q         <= IDLE_LEVEL;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Reference copy of the toggle FSM, tracking whatever is on y_out.
      case (exp_state_q)
        1'b0: if (!y_q) exp_state_q <= 1'b1;
        1'b1: if (y_q)  exp_state_q <= 1'b0;
        default: exp_state_q <= 1'b0;
      endcase

      case (ctrl_q)
        IDLE: begin
          y_q    <= IDLE_LEVEL;
          busy_q <= 1'b0;
          if (start) begin
            pat_q  <= pattern >> 1;
            len_q  <= len_clamped;
            err_q  <= '0;
            pass_q <= 1'b0;
            if (len_clamped == '0) begin
              ctrl_q <= SETTLE;
            end else begin
              ctrl_q <= DRIVE;
              y_q    <= pattern[0];
              idx_q  <= LEN_W'(1);
              busy_q <= 1'b1;
            end
          end
        end
        DRIVE: begin
          err_q <= err_d;
          if (idx_q < len_q) begin
            y_q   <= pat_q[0];
            pat_q <= pat_q >> 1;
            idx_q <= idx_q + LEN_W'(1);
          end else begin
            ctrl_q <= SETTLE;
          end
        end
        SETTLE: begin
          // Final compare covers the response to the last driven bit.
          err_q  <= err_d;
          pass_q <= (err_d == '0);
          y_q    <= IDLE_LEVEL;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          idx_q  <= '0;
          ctrl_q <= IDLE;
        end
        default: ctrl_q <= IDLE;
      endcase
    end
  end

  assign y_out     = y_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_fsm_stimulus_checker.sv
// tb/tb_fsm_stimulus_checker.sv - directed and randomized self-check of fsm_stimulus_checker
module tb_fsm_stimulus_checker;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] pattern;
  logic [4:0]  length;
  logic        y_out;
  logic        x_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_count;

  int compared   = 0;
  int mismatched = 0;

  // 0: healthy FSM, 1: x stuck 0, 2: x stuck 1, 3: x inverted
  int   x_mode = 0;
  logic fsm_s;

  always #5 clock = ~clock;

  fsm_stimulus_checker dut (
    .clock(clock), .reset(reset), .start(start), .pattern(pattern), .length(length),
    .y_out(y_out), .x_in(x_in), .busy(busy), .done(done), .pass(pass), .err_count(err_count)
  );

  // Board-side toggle FSM being exercised, sharing the checker reset.
  always @(posedge clock or posedge reset) begin
    if (reset) fsm_s <= 1'b0;
    else if (!fsm_s && !y_out) fsm_s <= 1'b1;
    else if (fsm_s && y_out) fsm_s <= 1'b0;
  end

  always_comb begin
    case (x_mode)
      1:       x_in = 1'b0;
      2:       x_in = 1'b1;
      3:       x_in = ~fsm_s;
      default: x_in = fsm_s;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One run from IDLE. rs_k > 0 re-pulses start just before edge E(rs_k).
  task automatic run_one(input logic [15:0] pat, input int len, input int mode, input int rs_k);
    int L;
    int d[0:17];
    int errs;
    logic obs_x;
    L = (len > 16) ? 16 : len;
    // d[k] is the level on y at edge Ek; compare k sees the FSM state ~d[k-1].
    d[0] = 1;
    for (int k = 1; k <= L; k++) d[k] = int'(pat[k-1]);
    d[L+1] = (L > 0) ? int'(pat[L-1]) : 1;
    errs = 0;
    for (int k = 1; k <= L + 1; k++) begin
      case (mode)
        1:       obs_x = 1'b0;
        2:       obs_x = 1'b1;
        3:       obs_x = d[k-1][0];
        default: obs_x = ~d[k-1][0];
      endcase
      if (obs_x != ~d[k-1][0]) errs++;
    end
    if (errs > 31) errs = 31;

    x_mode  = mode;
    pattern = pat;
    length  = len[4:0];
    start   = 1'b1;
    step();
    start   = 1'b0;
    check("pass_cleared", 32'(pass), 0);
    for (int k = 1; k <= L + 1; k++) begin
      check($sformatf("y_k%0d_len%0d", k, L), 32'(y_out), d[k]);
      check("busy_run", 32'(busy), (L > 0) ? 1 : 0);
      check("done_early", 32'(done), 0);
      if (k == rs_k) start = 1'b1;
      step();
      start = 1'b0;
    end
    check("done_pulse", 32'(done), 1);
    check("busy_end", 32'(busy), 0);
    check("y_idle_end", 32'(y_out), 1);
    check($sformatf("err_len%0d_mode%0d", L, mode), 32'(err_count), errs);
    check("pass_end", 32'(pass), (errs == 0) ? 1 : 0);
    step();
    check("done_one_cycle", 32'(done), 0);
    check("pass_held", 32'(pass), (errs == 0) ? 1 : 0);
  endtask

  initial begin
    int seen;
    reset   = 1'b1;
    start   = 1'b0;
    pattern = '0;
    length  = '0;
    step();
    check("rst_y", 32'(y_out), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_err", 32'(err_count), 0);
    reset = 1'b0;
    step();

    run_one(16'b0110, 4, 0, 0);
    run_one(16'hFFFF, 16, 1, 0);
    run_one(16'h0000, 3, 1, 0);
    run_one(16'h1234, 0, 0, 0);
    run_one(16'hA5C3, 31, 0, 0);
    run_one(16'b0110, 4, 0, 3);
    run_one(16'h00F0, 8, 3, 0);

    // Reset while driving bit 2.
    x_mode  = 0;
    pattern = 16'b0110;
    length  = 5'd4;
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    check("midrst_y", 32'(y_out), 1);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_err", 32'(err_count), 0);
    step();
    reset = 1'b0;
    seen  = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) seen++;
    end
    check("midrst_no_done", 32'(seen), 0);
    run_one(16'b0110, 4, 0, 0);

    // Start held high: the next run starts on the first IDLE edge after done.
    pattern = 16'b10;
    length  = 5'd2;
    start   = 1'b1;
    seen    = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      step();
      if (done) seen = 1;
    end
    check("held_done_seen", 32'(seen), 1);
    step();
    check("held_restart_busy", 32'(busy), 1);
    start = 1'b0;
    seen  = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      step();
      if (done) seen = 1;
    end
    check("held_second_done", 32'(seen), 1);
    check("held_second_pass", 32'(pass), 1);
    step();

    for (int r = 0; r < 24; r++) begin
      run_one(16'($urandom), int'($urandom_range(0, 20)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 6)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
